// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate format selects and skid-stage state encoding
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_RSVD
  } imm_sel_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} st_t;
endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: combinational RISC-V immediate decode and extension to XLEN
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);
  logic        s;
  logic [31:0] v32;
  logic        unused_opcode;
  assign s = instr[31];
  assign unused_opcode = ^instr[6:0];
  // Every format fits in 32 bits; all but SHAMT are then sign-extended to XLEN
  always_comb begin
    v32 = imm_sel == IMM_I     ? {{20{s}}, instr[31:20]} :
          imm_sel == IMM_S     ? {{20{s}}, instr[31:25], instr[11:7]} :
          imm_sel == IMM_B     ? {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_sel == IMM_U     ? {instr[31:12], 12'b0} :
          imm_sel == IMM_J     ? {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          imm_sel == IMM_SHAMT ? {26'b0, (XLEN == 64) & instr[25], instr[24:20]} :
          32'b0;
    imm = imm_sel == IMM_SHAMT ? XLEN'(v32) : XLEN'($signed(v32));
    err = imm_sel == IMM_RSVD;
  end
endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate generator with two-entry skid buffer and flush
module imm_ext_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_err
);
  if (ILEN != 32) begin : g_ilen_chk
    $error("imm_ext_stage: ILEN must be 32");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end
  st_t             st;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  logic [XLEN-1:0] skid_imm;
  logic            skid_err;
  logic            in_fire;
  assign in_fire = in_valid && in_ready;
  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr  (instr),
    .imm_sel(imm_sel_t'(imm_sel)),
    .imm    (ext_imm),
    .err    (ext_err)
  );
  // Handshake FSM; main entry drives outputs, skid catches one result under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      imm_out   <= '0;
      imm_err   <= 1'b0;
      skid_imm  <= '0;
      skid_err  <= 1'b0;
    end else if (flush) begin
      st        <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (st)
        ST_EMPTY: if (in_fire) begin
          st        <= ST_ONE;
          out_valid <= 1'b1;
          imm_out   <= ext_imm;
          imm_err   <= ext_err;
        end
        ST_ONE: if (in_fire && !out_ready) begin
          st       <= ST_TWO;
          in_ready <= 1'b0;
          skid_imm <= ext_imm;
          skid_err <= ext_err;
        end else if (in_fire) begin
          imm_out <= ext_imm;
          imm_err <= ext_err;
        end else if (out_ready) begin
          st        <= ST_EMPTY;
          out_valid <= 1'b0;
        end
        ST_TWO: if (out_ready) begin
          st       <= ST_ONE;
          in_ready <= 1'b1;
          imm_out  <= skid_imm;
          imm_err  <= skid_err;
        end
        default: st <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: scoreboard bench for the registered immediate stage
module tb_imm_ext_stage;
  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, imm_err;
  logic [31:0] instr, imm_out;
  logic [2:0]  imm_sel;
  logic        in_valid64, in_ready64, out_valid64, imm_err64;
  logic [31:0] instr64;
  logic [2:0]  imm_sel64;
  logic [63:0] imm_out64;
  int          compared = 0;
  int          mismatched = 0;
  logic [32:0] q[$];
  logic [32:0] mon_exp;

  imm_ext_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_sel(imm_sel), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .imm_err(imm_err)
  );
  imm_ext_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .imm_sel(imm_sel64), .out_valid(out_valid64), .out_ready(1'b1),
    .imm_out(imm_out64), .imm_err(imm_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected got imm=%h err=%b, expected nothing", imm_out, imm_err);
      end else begin
        mon_exp = q.pop_front();
        if ({imm_err, imm_out} !== mon_exp) begin
          mismatched++;
          $display("FAIL sb_data got err=%b imm=%h exp err=%b imm=%h",
                   imm_err, imm_out, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [31:0] e, input logic er);
    int n = 0;
    instr = i;
    imm_sel = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
    end else q.push_back({er, e});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send64(input string name, input logic [31:0] i, input logic [2:0] s, input logic [63:0] e);
    instr64 = i;
    imm_sel64 = s;
    in_valid64 = 1'b1;
    @(posedge clk);
    #1 in_valid64 = 1'b0;
    chk({name, "_valid"}, {63'b0, out_valid64}, 64'd1);
    chk(name, imm_out64, e);
  endtask

  logic [31:0] v_instr [8] = '{32'hFFF00093, 32'hFFF00093, 32'h00112623, 32'hFE000EE3,
                               32'h12345037, 32'h0080006F, 32'h01F09093, 32'hFFF00093};
  logic [2:0]  v_sel   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] v_exp   [8] = '{32'h0, 32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC,
                               32'h12345000, 32'h00000008, 32'h0000001F, 32'h0};
  logic        v_err   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_sel = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; instr64 = '0; imm_sel64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_imm_out", {32'b0, imm_out}, 64'd0);
    chk("rst_imm_err", {63'b0, imm_err}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      send(v_instr[k], v_sel[k], v_exp[k], v_err[k]);
      chk($sformatf("lat_valid_%0d", k), {63'b0, out_valid}, 64'd1);
      chk($sformatf("fmt_imm_%0d", k), {32'b0, imm_out}, {32'b0, v_exp[k]});
      chk($sformatf("fmt_err_%0d", k), {63'b0, imm_err}, {63'b0, v_err[k]});
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h00100013, 3'd1, 32'd1, 1'b0);
    send(32'h00200013, 3'd1, 32'd2, 1'b0);
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    chk("bp_hold_imm", {32'b0, imm_out}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp_stable_imm", {32'b0, imm_out}, 64'd1);
    chk("bp_stable_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    send(32'h00300013, 3'd1, 32'd3, 1'b0);
    chk("bp_no_gap_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_no_gap_imm", {32'b0, imm_out}, 64'd3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h00400013, 3'd1, 32'd4, 1'b0);
    send(32'h00500013, 3'd1, 32'd5, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    instr = 32'h00600013;
    imm_sel = 3'd1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(32'h00700013, 3'd1, 32'd7, 1'b0);
    chk("post_flush_imm", {32'b0, imm_out}, 64'd7);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h00800013, 3'd1, 32'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("async_rst_imm", {32'b0, imm_out}, 64'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send64("x64_u", 32'h80000037, 3'd4, 64'hFFFFFFFF80000000);
    send64("x64_shamt", 32'h03F09093, 3'd6, 64'h000000000000003F);
    send64("x64_i", 32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, registered immediate generator for the next-generation RISC-V pipeline. It takes a full instruction word and a format select from decode. It produces the sign- or zero-extended immediate at XLEN width, one cycle later, through a valid/ready handshake. It sits between decode and execute, replacing the fixed 3-bit combinational immediate extender. An internal two-entry skid buffer absorbs back-pressure, and a synchronous flush supports branch redirect.

## Interface
- XLEN, 32: immediate output width; legal values are 32 and 64.
- ILEN, 32: instruction width; fixed at 32 and checked at elaboration.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties the stage.
- in_valid  in  1  instruction and select are valid this cycle.
- in_ready  out  1  stage can accept an input this cycle.
- instr  in  ILEN  instruction word.
- imm_sel  in  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 reserved.
- out_valid  out  1  imm_out is valid.
- out_ready  in  1  downstream accepts the output.
- imm_out  out  XLEN  extended immediate.
- imm_err  out  1  the held entry had imm_sel = 7; qualified by out_valid.

## Operation
- Formats, with s = instr[31] replicated to fill XLEN:
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {s (XLEN>32 only), instr[31:12], 12'b0}.
  - J: {s, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - NONE: all zeros.
  - reserved: all zeros, with imm_err=1.
- Output is never X. An unselected or unused immediate is 0.
- Extension is purely combinational on the input side. The result, err and valid are captured into the entry registers.
- Storage: a main entry drives the outputs; a skid entry holds one extra result.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- States:
  - EMPTY: no entries.
  - ONE: main entry only.
  - TWO: main and skid entries.
- Transitions:
  - EMPTY: an input transfer moves to ONE.
  - ONE, input only: moves to TWO; the new data goes to skid.
  - ONE, output only: moves to EMPTY.
  - ONE, input and output: stays in ONE; main reloads with the new data.
  - TWO, output: skid moves to main and the state goes to ONE. in_ready is 0 in TWO, so no input is accepted.
- flush: the state goes to EMPTY next cycle regardless of other inputs. A same-cycle input is dropped, and the output is not considered transferred.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.

## Timing
- Latency is 1 cycle from an input transfer to out_valid, when the stage is empty.
- Throughput is 1 per cycle while out_ready is held high.
- Reset values:
  - out_valid=0, imm_out=0, imm_err=0.
  - in_ready=1.
  - State is EMPTY; skid data is 0.
- Asserting rst_n low mid-operation clears everything immediately, without waiting for a clock edge. The first input is accepted on the first rising edge after release.
- imm_out and imm_err are stable while out_valid && !out_ready.
- A flush takes priority over every other event in the same cycle.

## Structure
- Shared package imm_pkg, containing:
  - The imm_sel_t enum: IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_RSVD.
  - The state encoding: ST_EMPTY, ST_ONE, ST_TWO.
- One combinational sub-module, imm_ext_comb. Inputs: instr and imm_sel. Outputs: imm and err. Parameter: XLEN.
- The top level holds only the handshake state machine and the registers.

## Test plan
- Reset and NONE:
  - Hold rst_n=0 and check out_valid=0, in_ready=1, imm_out=0.
  - Release, then send 0xFFF00093 with NONE; check imm_out=0 and imm_err=0.
- Sign extension, out_ready=1, XLEN=32:
  - I, instr 0xFFF00093: expect 0xFFFFFFFF one cycle after the input transfer.
  - S, instr 0x00112623: expect 0x0000000C.
- Remaining formats, XLEN=32:
  - B, instr 0xFE000EE3: expect 0xFFFFFFFC.
  - U, instr 0x12345037: expect 0x12345000.
  - J, instr 0x0080006F: expect 0x00000008.
  - SHAMT, instr 0x01F09093: expect 0x0000001F.
- Back-pressure:
  - Stream I inputs with immediates 1, 2, 3 while out_ready=0.
  - Check in_ready falls after two accepted inputs and imm_out holds 1.
  - Raise out_ready and check outputs 1, 2, 3 in order, with no gaps after the first.
- Flush: in state TWO, assert flush together with in_valid. Next cycle check out_valid=0 and in_ready=1, and that the dropped input never appears.
- Reserved select and XLEN=64:
  - imm_sel=7 gives imm_out=0 and imm_err=1.
  - With XLEN=64, U on instr 0x80000037 gives 0xFFFFFFFF80000000.
